// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: bus widths and register offsets.
package gpio_bank_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    localparam logic [ADDR_W-1:0] ADDR_IN      = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_OUT     = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 6'h08;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 6'h0C;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 6'h10;
    localparam logic [ADDR_W-1:0] ADDR_PEND    = 6'h14;
    localparam logic [ADDR_W-1:0] ADDR_DEB_DIV = 6'h18;
    localparam logic [ADDR_W-1:0] ADDR_OUT_SET = 6'h1C;
    localparam logic [ADDR_W-1:0] ADDR_OUT_CLR = 6'h20;
endpackage

// File: rtl/gpio_bank_if.sv
// Peripheral bus seen by the GPIO bank: sel/write request, one-cycle ready response.
interface gpio_bank_if;
    import gpio_bank_pkg::*;

    logic              sel;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output sel, write, addr, wdata, input rdata, ready);
    modport slave  (input sel, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/gpio_pin_filter.sv
// One pin's input path: synchroniser chain, then a two-sample agreement filter
// that only updates on prescaler ticks.
module gpio_pin_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    input  logic tick,
    output logic filt
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            // A level is accepted only once it has been seen on two consecutive ticks
            if (tick) begin
                if (s == prev)
                    filt <= s;
                prev <= s;
            end
        end
    end
endmodule

// File: rtl/gpio_bank.sv
// N-pin GPIO bank: register file, debounce prescaler, edge detection and
// pending/interrupt logic; per-pin input filtering lives in gpio_pin_filter.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int PINS        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic            io_sys_clock,
    input  logic            io_sys_resetn,
    gpio_bank_if.slave      bus,
    input  logic [PINS-1:0] io_pins_read,
    output logic [PINS-1:0] io_pins_write,
    output logic [PINS-1:0] io_pins_writeEnable,
    output logic            io_irq
);
    logic [PINS-1:0]   out_q, dir_q, rise_en_q, fall_en_q, pend_q;
    logic [PINS-1:0]   filt, filt_p1;
    logic [PINS-1:0]   wdata_pins, pend_set, pend_clr;
    logic [DEB_W-1:0]  deb_div_q, presc_q;
    logic [DATA_W-1:0] rdata_nxt;
    logic              accept, wr, tick;
    logic              unused_wdata;

    // An access is accepted only while ready is low, so a held sel restarts two cycles later
    assign accept       = bus.sel & ~bus.ready;
    assign wr           = accept & bus.write;
    assign wdata_pins   = bus.wdata[PINS-1:0];
    assign unused_wdata = ^bus.wdata;
    assign tick         = (presc_q == deb_div_q);

    assign pend_set = (filt & ~filt_p1 & rise_en_q) | (~filt & filt_p1 & fall_en_q);
    assign pend_clr = (wr && bus.addr == ADDR_PEND) ? wdata_pins : '0;

    assign io_pins_write       = out_q;
    assign io_pins_writeEnable = dir_q;

    for (genvar i = 0; i < PINS; i++) begin : g_pin
        gpio_pin_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
            .clk   (io_sys_clock),
            .rst_n (io_sys_resetn),
            .pad   (io_pins_read[i]),
            .tick  (tick),
            .filt  (filt[i])
        );
    end

    always_comb begin
        rdata_nxt = '0;
        case (bus.addr)
            ADDR_IN:      rdata_nxt[PINS-1:0]  = filt;
            ADDR_OUT:     rdata_nxt[PINS-1:0]  = out_q;
            ADDR_DIR:     rdata_nxt[PINS-1:0]  = dir_q;
            ADDR_RISE_EN: rdata_nxt[PINS-1:0]  = rise_en_q;
            ADDR_FALL_EN: rdata_nxt[PINS-1:0]  = fall_en_q;
            ADDR_PEND:    rdata_nxt[PINS-1:0]  = pend_q;
            ADDR_DEB_DIV: rdata_nxt[DEB_W-1:0] = deb_div_q;
            default:      rdata_nxt            = '0;
        endcase
    end

    always_ff @(posedge io_sys_clock) begin
        if (!io_sys_resetn) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= accept;
            if (accept)
                bus.rdata <= bus.write ? '0 : rdata_nxt;
        end
    end

    always_ff @(posedge io_sys_clock) begin
        if (!io_sys_resetn)
            presc_q <= '0;
        else if ((wr && bus.addr == ADDR_DEB_DIV) || tick)
            presc_q <= '0;
        else
            presc_q <= presc_q + 1'b1;
    end

    always_ff @(posedge io_sys_clock) begin
        if (!io_sys_resetn) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            deb_div_q <= '0;
            filt_p1   <= '0;
            io_irq    <= 1'b0;
        end else begin
            if (wr) begin
                case (bus.addr)
                    ADDR_OUT:     out_q     <= wdata_pins;
                    ADDR_DIR:     dir_q     <= wdata_pins;
                    ADDR_RISE_EN: rise_en_q <= wdata_pins;
                    ADDR_FALL_EN: fall_en_q <= wdata_pins;
                    ADDR_DEB_DIV: deb_div_q <= bus.wdata[DEB_W-1:0];
                    ADDR_OUT_SET: out_q     <= out_q | wdata_pins;
                    ADDR_OUT_CLR: out_q     <= out_q & ~wdata_pins;
                    default:      ;
                endcase
            end
            // New events win over a W1C landing in the same cycle
            pend_q  <= (pend_q & ~pend_clr) | pend_set;
            filt_p1 <= filt;
            io_irq  <= |pend_q;
        end
    end
endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: registers, atomic set/clear, debounce, edge interrupts, reset.
module tb_gpio_bank;
    import gpio_bank_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  pins_read, pins_write, pins_we;
    logic        irq;
    logic [31:0] rd;
    int          checks = 0;
    int          failures = 0;

    gpio_bank_if bus ();

    gpio_bank #(.PINS(4), .SYNC_STAGES(2), .DEB_W(16)) dut (
        .io_sys_clock        (clk),
        .io_sys_resetn       (resetn),
        .bus                 (bus),
        .io_pins_read        (pins_read),
        .io_pins_write       (pins_write),
        .io_pins_writeEnable (pins_we),
        .io_irq              (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.sel = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        chk("wr_ready", {31'b0, bus.ready}, 32'd1);
        bus.sel = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.sel = 1'b1; bus.write = 1'b0; bus.addr = a;
        @(posedge clk); #1;
        chk("rd_ready", {31'b0, bus.ready}, 32'd1);
        d = bus.rdata;
        bus.sel = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; pins_read = 4'h0;
        bus.sel = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {28'b0, pins_we}, 32'h0);
        chk("rst_out", {28'b0, pins_write}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_ready", {31'b0, bus.ready}, 32'h0);
        resetn = 1'b1;
        bus_read(ADDR_IN, rd);       chk("rst_in", rd, 32'h0);

        // Outputs and atomic set/clear
        bus_write(ADDR_DIR, 32'hF);
        bus_write(ADDR_OUT, 32'h5);
        chk("out_write", {28'b0, pins_write}, 32'h5);
        chk("dir_we", {28'b0, pins_we}, 32'hF);
        bus_write(ADDR_OUT_SET, 32'h2); chk("out_set", {28'b0, pins_write}, 32'h7);
        bus_write(ADDR_OUT_CLR, 32'h4); chk("out_clr", {28'b0, pins_write}, 32'h3);
        bus_read(ADDR_OUT, rd);       chk("rd_out", rd, 32'h3);
        bus_read(ADDR_OUT_SET, rd);   chk("rd_out_set", rd, 32'h0);
        bus_read(ADDR_DIR, rd);       chk("rd_dir", rd, 32'hF);
        bus_write(ADDR_DIR, 32'h0);   chk("dir_off", {28'b0, pins_we}, 32'h0);

        // Debounce with DEB_DIV=3: a 2-cycle glitch is rejected, a held level passes
        bus_write(ADDR_DEB_DIV, 32'h3);
        bus_read(ADDR_DEB_DIV, rd);   chk("rd_deb_div", rd, 32'h3);
        pins_read[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 pins_read[0] = 1'b0;
        repeat (20) @(posedge clk);
        bus_read(ADDR_IN, rd);        chk("glitch_in", rd, 32'h0);
        pins_read[0] = 1'b1;
        bus_read(ADDR_IN, rd);        chk("deb_early", rd, 32'h0);
        repeat (8) @(posedge clk);
        bus_read(ADDR_IN, rd);        chk("deb_settle", rd, 32'h1);
        repeat (20) @(posedge clk);
        bus_read(ADDR_IN, rd);        chk("deb_hold", rd, 32'h1);

        // Edge interrupts with the filter ticking every cycle
        bus_write(ADDR_DEB_DIV, 32'h0);
        pins_read = 4'b0010;
        repeat (20) @(posedge clk);
        bus_read(ADDR_PEND, rd);      chk("pend_none", rd, 32'h0);
        chk("irq_none", {31'b0, irq}, 32'h0);
        bus_write(ADDR_RISE_EN, 32'h1);
        bus_write(ADDR_FALL_EN, 32'h2);
        pins_read[0] = 1'b1;
        repeat (10) @(posedge clk);
        bus_read(ADDR_PEND, rd);      chk("pend_rise0", rd, 32'h1);
        chk("irq_rise0", {31'b0, irq}, 32'h1);
        pins_read[1] = 1'b0;
        repeat (10) @(posedge clk);
        bus_read(ADDR_PEND, rd);      chk("pend_fall1", rd, 32'h3);
        bus_write(ADDR_PEND, 32'h1);
        bus_read(ADDR_PEND, rd);      chk("pend_w1c0", rd, 32'h2);
        chk("irq_still", {31'b0, irq}, 32'h1);
        bus_write(ADDR_PEND, 32'h2);
        chk("irq_lag", {31'b0, irq}, 32'h1);
        @(posedge clk); #1;
        chk("irq_clear", {31'b0, irq}, 32'h0);
        bus_read(ADDR_PEND, rd);      chk("pend_empty", rd, 32'h0);

        // W1C on pin0 lands on the same edge the new pin0 rise sets PEND[0]
        pins_read[0] = 1'b0;
        repeat (10) @(posedge clk);
        bus_read(ADDR_PEND, rd);      chk("pend_pre", rd, 32'h0);
        pins_read[0] = 1'b1;
        repeat (3) @(posedge clk);
        bus_write(ADDR_PEND, 32'h1);
        bus_read(ADDR_PEND, rd);      chk("set_wins", rd, 32'h1);
        chk("irq_set_wins", {31'b0, irq}, 32'h1);
        bus_write(ADDR_PEND, 32'h1);
        bus_read(ADDR_PEND, rd);      chk("pend_cleared", rd, 32'h0);

        // Unmapped address, and ready behaviour under a held sel
        bus_read(6'h3C, rd);          chk("rd_unmapped", rd, 32'h0);
        @(posedge clk); #1;
        chk("ready_drop", {31'b0, bus.ready}, 32'h0);
        bus.sel = 1'b1; bus.write = 1'b0; bus.addr = ADDR_OUT;
        @(posedge clk); #1;
        chk("held_ready1", {31'b0, bus.ready}, 32'h1);
        chk("held_rdata", bus.rdata, 32'h3);
        @(posedge clk); #1;
        chk("held_gap", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        chk("held_ready2", {31'b0, bus.ready}, 32'h1);
        bus.sel = 1'b0;
        @(posedge clk); #1;

        // Reset while an access is being requested
        bus.sel = 1'b1; bus.write = 1'b0; bus.addr = ADDR_OUT;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_ready", {31'b0, bus.ready}, 32'h0);
        end
        chk("rst2_out", {28'b0, pins_write}, 32'h0);
        chk("rst2_irq", {31'b0, irq}, 32'h0);
        bus.sel = 1'b0;
        resetn = 1'b1;
        bus_read(ADDR_OUT, rd);       chk("rst2_rd_out", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
